sdram_ctrl_refresh_timer: RTL and testbench

Power-up delay and refresh request generator for the AHB3-Lite multi-port SDRAM controller. Sits directly upstream of the command scheduler. Consumes `ctrl.ena` and `tREF` from the CSR block, produces the `init_done` status bit and a pending-refresh request/acknowledge handshake. The scheduler turns each acknowledged request into a `CMD_REF`.

---
 rtl/sdram_ctrl_pkg.sv | 22 ++
 rtl/sdram_ctrl_dcnt.sv | 30 +++
 rtl/sdram_ctrl_refresh_timer.sv | 165 ++++++++++++++++
 tb/tb_sdram_ctrl_refresh_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_pkg.sv
// Shared types and constants for the SDRAM controller refresh path.
package sdram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_INIT_DLY = 2'd1,
    ST_RUN      = 2'd2
  } refresh_timer_state_t;

  localparam int REF_PENDING_BITS = 4;
  localparam int TREF_BITS        = 16;

  // Reload value for the tick counter; a zero interval parks the counter at 0.
  function automatic logic [TREF_BITS-1:0] tref_reload(input logic [TREF_BITS-1:0] tref);
    if (tref != 16'd0) begin
      return tref - 16'd1;
    end else begin
      return 16'd0;
    end
  endfunction

endpackage

// File: rtl/sdram_ctrl_dcnt.sv
// Loadable down-counter that stops at zero and flags it; load wins over decrement.
module sdram_ctrl_dcnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_is_zero
);

  logic [W-1:0] r_cnt;

  // Count register: load, saturating decrement, or hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_is_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/sdram_ctrl_refresh_timer.sv
// Power-up delay and refresh request generator feeding the command scheduler.
// Define SDRAM_CTRL_REF_POSTPONE_EN to allow up to MAX_PENDING postponed refreshes.
module sdram_ctrl_refresh_timer
  import sdram_ctrl_pkg::*;
#(
  parameter int INIT_DLY_CNT = 25000,
  parameter int MAX_PENDING  = 8
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        csr_ena,
  input  logic [TREF_BITS-1:0]        csr_tref,
  output logic                        init_done,
  output logic                        ref_req,
  output logic                        ref_urgent,
  input  logic                        ref_ack,
  output logic [REF_PENDING_BITS-1:0] ref_pending,
  output logic                        ref_ovf
);

  localparam int INIT_W = (INIT_DLY_CNT > 1) ? $clog2(INIT_DLY_CNT) : 1;

`ifdef SDRAM_CTRL_REF_POSTPONE_EN
  localparam logic [REF_PENDING_BITS-1:0] REF_MAX = REF_PENDING_BITS'(MAX_PENDING);
`else
  localparam logic [REF_PENDING_BITS-1:0] REF_MAX = 4'd1;
`endif

  if ((INIT_DLY_CNT < 1) || (MAX_PENDING < 2) || (MAX_PENDING > 15)) begin : g_param_chk
    $error("sdram_ctrl_refresh_timer: INIT_DLY_CNT or MAX_PENDING out of range");
  end

  refresh_timer_state_t              r_state;
  logic                              r_init_done;
  logic                              r_ovf;
  logic [REF_PENDING_BITS-1:0]       r_pend;

  logic                              w_init_load;
  logic                              w_init_dec;
  logic                              w_init_zero;
  logic                              w_tick_load;
  logic [TREF_BITS-1:0]              w_tick_val;
  logic                              w_tick_dec;
  logic                              w_tick_zero;
  logic                              w_tick;
  logic                              w_ack_eff;

  assign w_ack_eff = ref_ack && (r_pend != 4'd0);

  // Counter controls and tick generation, decoded from the current state.
  always_comb begin
    w_init_load = 1'b0;
    w_init_dec  = 1'b0;
    w_tick_load = 1'b0;
    w_tick_val  = 16'd0;
    w_tick_dec  = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      ST_OFF: begin
        w_init_load = csr_ena;
        w_tick_load = 1'b1;
      end
      ST_INIT_DLY: begin
        if (!csr_ena) begin
          w_init_dec = 1'b0;
        end else if (w_init_zero) begin
          w_tick_load = 1'b1;
          w_tick_val  = tref_reload(csr_tref);
        end else begin
          w_init_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (!csr_ena) begin
          w_tick_dec = 1'b0;
        end else if (csr_tref == 16'd0) begin
          w_tick_load = 1'b1;
        end else if (w_tick_zero) begin
          w_tick      = 1'b1;
          w_tick_load = 1'b1;
          w_tick_val  = tref_reload(csr_tref);
        end else begin
          w_tick_dec = 1'b1;
        end
      end
      default: begin
        w_tick_load = 1'b1;
      end
    endcase
  end

  sdram_ctrl_dcnt #(.W(INIT_W)) u_init_cnt (
    .i_clk      (HCLK),
    .i_rst      (HRESET),
    .i_load     (w_init_load),
    .i_load_val (INIT_W'(INIT_DLY_CNT - 1)),
    .i_dec      (w_init_dec),
    .o_is_zero  (w_init_zero)
  );

  sdram_ctrl_dcnt #(.W(TREF_BITS)) u_tick_cnt (
    .i_clk      (HCLK),
    .i_rst      (HRESET),
    .i_load     (w_tick_load),
    .i_load_val (w_tick_val),
    .i_dec      (w_tick_dec),
    .o_is_zero  (w_tick_zero)
  );

  // State machine with sticky status bits and the pending-refresh count.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_OFF;
      r_init_done <= 1'b0;
      r_ovf       <= 1'b0;
      r_pend      <= 4'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_pend <= 4'd0;
          r_ovf  <= 1'b0;
          if (csr_ena) begin
            r_state <= ST_INIT_DLY;
          end else begin
            r_state <= ST_OFF;
          end
        end
        ST_INIT_DLY: begin
          if (!csr_ena) begin
            r_state <= ST_OFF;
          end else if (w_init_zero) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_state <= ST_INIT_DLY;
          end
        end
        ST_RUN: begin
          // Acks still drain the count while disabled; only ticks stop.
          if (w_tick && !w_ack_eff) begin
            if (r_pend == REF_MAX) begin
              r_ovf <= 1'b1;
            end else begin
              r_pend <= r_pend + 4'd1;
            end
          end else if (!w_tick && w_ack_eff) begin
            r_pend <= r_pend - 4'd1;
          end else begin
            r_pend <= r_pend;
          end
        end
        default: begin
          r_state <= ST_OFF;
        end
      endcase
    end
  end

  assign init_done   = r_init_done;
  assign ref_ovf     = r_ovf;
  assign ref_pending = r_pend;
  assign ref_req     = (r_pend != 4'd0);
  assign ref_urgent  = (r_pend == REF_MAX);

endmodule

// File: tb/tb_sdram_ctrl_refresh_timer.sv
// Scoreboard bench: expected pending/overflow events are queued as stimulus is driven.
module tb_sdram_ctrl_refresh_timer;

  localparam int INIT_N = 10;
`ifdef SDRAM_CTRL_REF_POSTPONE_EN
  localparam int MAXP = 8;
`else
  localparam int MAXP = 1;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        csr_ena = 1'b0;
  logic [15:0] csr_tref = 16'd0;
  logic        ref_ack = 1'b0;
  logic        init_done;
  logic        ref_req;
  logic        ref_urgent;
  logic [3:0]  ref_pending;
  logic        ref_ovf;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int last_pend = 0;
  int last_ovf = 0;

  typedef struct {
    int edge_n;
    int pend;
    int ovf;
  } ev_t;
  ev_t sb_q[$];
  ev_t mon_e;

  int k;
  int t1;
  int tt;
  int p_cnt;
  int nt;
  int tick_e[4];

  sdram_ctrl_refresh_timer #(
    .INIT_DLY_CNT (INIT_N),
    .MAX_PENDING  (8)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .csr_ena     (csr_ena),
    .csr_tref    (csr_tref),
    .init_done   (init_done),
    .ref_req     (ref_req),
    .ref_urgent  (ref_urgent),
    .ref_ack     (ref_ack),
    .ref_pending (ref_pending),
    .ref_ovf     (ref_ovf)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_ev(input int e, input int p, input int o);
    sb_q.push_back('{edge_n: e, pend: p, ovf: o});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge HCLK);
  endtask

  task automatic enable_at(output int kk);
    kk = cyc + 1;
    csr_ena = 1'b1;
  endtask

  task automatic pulse_ack(input int e);
    wait_cyc(e - 1);
    ref_ack = 1'b1;
    wait_cyc(e);
    ref_ack = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] tref);
    mon_en   = 1'b0;
    HRESET   = 1'b1;
    csr_ena  = 1'b0;
    ref_ack  = 1'b0;
    csr_tref = tref;
    repeat (2) @(negedge HCLK);
    check_val("rst_outputs", int'({init_done, ref_req, ref_urgent, ref_ovf, ref_pending}), 0);
    HRESET = 1'b0;
    sb_q.delete();
    mon_en = 1'b1;
  endtask

  // Every change of pending count or overflow must match the next queued event.
  always @(negedge HCLK) begin
    if (mon_en) begin
      if ((int'(ref_pending) != last_pend) || (int'(ref_ovf) != last_ovf)) begin
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected", int'(ref_pending) * 2 + int'(ref_ovf), last_pend * 2 + last_ovf);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("ev_edge", cyc, mon_e.edge_n);
          check_val("ev_pending", int'(ref_pending), mon_e.pend);
          check_val("ev_ovf", int'(ref_ovf), mon_e.ovf);
          check_val("ev_req", int'(ref_req), int'(mon_e.pend != 0));
          check_val("ev_urgent", int'(ref_urgent), int'(mon_e.pend == MAXP));
        end
      end
    end
    last_pend <= int'(ref_pending);
    last_ovf  <= int'(ref_ovf);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up delay completes exactly INIT_N edges after enable.
    do_reset(16'd0);
    enable_at(k);
    wait_cyc(k + INIT_N - 1);
    check_val("init_early", int'(init_done), 0);
    wait_cyc(k + INIT_N);
    check_val("init_done", int'(init_done), 1);
    wait_cyc(k + INIT_N + 40);
    check_val("tref0_no_req", int'(ref_req), 0);

    // Enable dropped during the delay restarts it in full.
    do_reset(16'd0);
    enable_at(k);
    wait_cyc(k + 6);
    csr_ena = 1'b0;
    wait_cyc(k + 12);
    check_val("abort_init", int'(init_done), 0);
    enable_at(k);
    wait_cyc(k + INIT_N - 1);
    check_val("restart_early", int'(init_done), 0);
    wait_cyc(k + INIT_N);
    check_val("restart_done", int'(init_done), 1);

    // Ticks without acks saturate at the maximum and then flag overflow.
    do_reset((MAXP == 1) ? 16'd50 : 16'd100);
    enable_at(k);
    nt = MAXP + 1;
    for (int j = 1; j <= nt; j++) begin
      push_ev(k + INIT_N + int'(csr_tref) * j, (j > MAXP) ? MAXP : j, int'(j > MAXP));
    end
    wait_cyc(k + INIT_N + int'(csr_tref) * nt + 5);
    check_val("sb_drain_sat", sb_q.size(), 0);
    check_val("urgent_sat", int'(ref_urgent), 1);

    // Tick and ack on one edge leave the count; ack at zero is ignored.
    p_cnt = (MAXP >= 3) ? 3 : 1;
    do_reset(16'd20);
    enable_at(k);
    t1 = k + INIT_N;
    for (int j = 1; j <= p_cnt; j++) push_ev(t1 + 20 * j, j, 0);
    tt = t1 + 20 * (p_cnt + 1);
    for (int i = 1; i <= p_cnt; i++) push_ev(tt + 2 * i, p_cnt - i, 0);
    push_ev(tt + 20, 1, 0);
    pulse_ack(tt);
    check_val("tick_ack_same", int'(ref_pending), p_cnt);
    for (int i = 1; i <= p_cnt; i++) pulse_ack(tt + 2 * i);
    pulse_ack(tt + 2 * p_cnt + 2);
    check_val("ack_at_zero", int'(ref_pending), 0);
    check_val("ack_zero_ovf", int'(ref_ovf), 0);
    wait_cyc(tt + 25);
    check_val("sb_drain_ack", sb_q.size(), 0);

    // New interval applies at the next reload; zero interval stops ticks.
    do_reset(16'd100);
    enable_at(k);
    tick_e[0] = k + INIT_N + 100;
    tick_e[1] = tick_e[0] + 100;
    tick_e[2] = tick_e[1] + 20;
    tick_e[3] = tick_e[2] + 20;
    for (int j = 0; j < 4; j++) begin
      push_ev(tick_e[j], 1, 0);
      push_ev(tick_e[j] + 1, 0, 0);
    end
    pulse_ack(tick_e[0] + 1);
    wait_cyc(tick_e[0] + 30);
    csr_tref = 16'd20;
    for (int j = 1; j < 4; j++) pulse_ack(tick_e[j] + 1);
    wait_cyc(tick_e[3] + 5);
    csr_tref = 16'd0;
    wait_cyc(tick_e[3] + 150);
    check_val("sb_drain_tref", sb_q.size(), 0);
    check_val("tref0_pending", int'(ref_pending), 0);

    // Asynchronous reset clears everything between clock edges.
    p_cnt = (MAXP >= 5) ? 5 : 1;
    do_reset(16'd20);
    enable_at(k);
    for (int j = 1; j <= p_cnt; j++) push_ev(k + INIT_N + 20 * j, j, 0);
    wait_cyc(k + INIT_N + 20 * p_cnt + 3);
    check_val("pre_rst_pending", int'(ref_pending), p_cnt);
    check_val("sb_drain_rst", sb_q.size(), 0);
    mon_en = 1'b0;
    @(posedge HCLK);
    #2;
    HRESET = 1'b1;
    #1;
    check_val("arst_pending", int'(ref_pending), 0);
    check_val("arst_req", int'(ref_req), 0);
    check_val("arst_urgent", int'(ref_urgent), 0);
    check_val("arst_init_done", int'(init_done), 0);
    check_val("arst_ovf", int'(ref_ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
